dmp_periph_initiator: RTL

DMP-side master for the customer peripheral port on the data-memory pipeline.
- Accepts one load/store at a time from the load/store unit when the address falls in the peripheral aperture.
- Drives registered address, write data and strobes to the peripheral, honours p_stall, and captures p_drd on p_ldvalid.
- Aligns and extends load data, then returns it to the writeback path with its register tag.
- The peripheral on the other side of this interface drives p_ldvalid, p_drd and p_stall.

---
 rtl/dmp_periph_pkg.sv | 29 ++
 rtl/dmp_periph_ldalign.sv | 35 +++
 rtl/dmp_periph_initiator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dmp_periph_pkg.sv
// Shared types and helpers for the DMP peripheral-port initiator.
package dmp_periph_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] APER_BASE_DEF = 32'hFF00_0000;
  localparam logic [31:0] APER_MASK_DEF = 32'hFF00_0000;

  function automatic logic [3:0] be_of(
    input logic [1:0] size,
    input logic [1:0] a
  );
    case (size)
      SZ_B:    be_of = 4'b0001 << a;
      SZ_H:    be_of = 4'b0011 << {a[1], 1'b0};
      default: be_of = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmp_periph_ldalign.sv
// Lane select / extension of read data, plus store-lane replication.
module dmp_periph_ldalign
  import dmp_periph_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] aligned,
  output logic [31:0] repl
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign bsel = data[{off, 3'b000} +: 8];
  assign hsel = data[{off[1], 4'b0000} +: 16];

  always_comb begin
    aligned = data;
    repl    = data;
    case (size)
      SZ_B: begin
        aligned = {{24{sext & bsel[7]}}, bsel};
        repl    = {4{data[7:0]}};
      end
      SZ_H: begin
        aligned = {{16{sext & hsel[15]}}, hsel};
        repl    = {2{data[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmp_periph_initiator.sv
// DMP master for the peripheral aperture: one load/store at a time.
// Optional response timeout enabled by DMP_PERIPH_TIMEOUT_EN.
module dmp_periph_initiator
  import dmp_periph_pkg::*;
#(
  parameter logic [31:0] APER_BASE = APER_BASE_DEF,
  parameter logic [31:0] APER_MASK = APER_MASK_DEF,
  parameter int          TAG_W     = 6,
  parameter int          TMO_CYC   = 255
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             mc_req,
  input  logic [31:0]      mc_addr,
  input  logic [31:0]      mc_wdata,
  input  logic             mc_store,
  input  logic [1:0]       mc_size,
  input  logic             mc_sext,
  input  logic [TAG_W-1:0] mc_tag,
  output logic             mc_hit,
  output logic             mc_ack,
  output logic             mc_busy,
  output logic             p_req,
  output logic [31:0]      p_addr,
  output logic [31:0]      p_wdata,
  output logic             p_we,
  output logic [3:0]       p_be,
  input  logic             p_ldvalid,
  input  logic [31:0]      p_drd,
  input  logic             p_stall,
  output logic             ld_valid,
  output logic [31:0]      ld_data,
  output logic [TAG_W-1:0] ld_tag,
  output logic             ld_err
);

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        store_q;
  logic        idle;
  logic        done;
  logic        tmo;
  logic        tmo_fire;
  logic [31:0] al_data;
  logic [31:0] al_out;
  logic [31:0] al_rep;

  assign idle    = (state == IDLE);
  assign mc_hit  = ((mc_addr & APER_MASK) == APER_BASE);
  assign mc_ack  = mc_req & mc_hit & idle;
  assign mc_busy = ~idle;

  // One aligner: replicates store data when idle, aligns read data otherwise.
  assign al_data = idle ? mc_wdata : p_drd;

  dmp_periph_ldalign u_align (
    .data    (al_data),
    .off     (idle ? mc_addr[1:0] : off_q),
    .size    (idle ? mc_size : size_q),
    .sext    (idle ? mc_sext : sext_q),
    .aligned (al_out),
    .repl    (al_rep)
  );

  assign done = ((state == REQ) & ~p_stall) |
                ((state == WAIT) & p_ldvalid);
  assign tmo_fire = tmo & ~done;

`ifdef DMP_PERIPH_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;

  // Counts from REQ entry through WAIT; IDLE holds it at zero.
  assign tmo = ((state == REQ) | (state == WAIT)) &
               (cnt == 8'(TMO_CYC - 1));
  assign ld_err = err_q;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= idle ? 8'd0 : cnt + 8'd1;
      err_q <= tmo_fire & ~store_q;
    end
  end
`else
  assign tmo    = 1'b0;
  assign ld_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state    <= IDLE;
      p_req    <= 1'b0;
      p_addr   <= '0;
      p_wdata  <= '0;
      p_we     <= 1'b0;
      p_be     <= '0;
      ld_valid <= 1'b0;
      ld_data  <= '0;
      ld_tag   <= '0;
      off_q    <= '0;
      size_q   <= '0;
      sext_q   <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      unique case (state)
        IDLE: if (mc_ack) begin
          state   <= REQ;
          p_req   <= 1'b1;
          p_addr  <= {mc_addr[31:2], 2'b00};
          p_wdata <= al_rep;
          p_we    <= mc_store;
          p_be    <= be_of(mc_size, mc_addr[1:0]);
          off_q   <= mc_addr[1:0];
          size_q  <= mc_size;
          sext_q  <= mc_sext;
          store_q <= mc_store;
          ld_tag  <= mc_tag;
        end
        REQ: if (!p_stall) begin
          p_req <= 1'b0;
          if (store_q) begin
            state <= IDLE;
          end else if (p_ldvalid) begin
            state    <= RESP;
            ld_valid <= 1'b1;
            ld_data  <= al_out;
          end else begin
            state <= WAIT;
          end
        end else if (tmo_fire) begin
          p_req <= 1'b0;
          if (store_q) begin
            state <= IDLE;
          end else begin
            state    <= RESP;
            ld_valid <= 1'b1;
            ld_data  <= '0;
          end
        end
        WAIT: if (p_ldvalid) begin
          state    <= RESP;
          ld_valid <= 1'b1;
          ld_data  <= al_out;
        end else if (tmo_fire) begin
          state    <= RESP;
          ld_valid <= 1'b1;
          ld_data  <= '0;
        end
        RESP: state <= IDLE;
      endcase
    end
  end

endmodule
